// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and the ReLU helper for the 2x2 convolution core.
// No ports.
package conv_pkg;

  localparam int IMG_DIM = 8;
  localparam int K_DIM   = 2;
  localparam int OUT_DIM = 7;
  localparam int DATA_W  = 32;

  typedef enum logic [1:0] {
    StIdle,
    StKload,
    StWin,
    StDone
  } state_e;

  // Negative (bit 31 set) results clamp to zero.
  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/conv_win_ctr.sv
// Window / kernel-tap counters and the derived memory addresses for the convolution core.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_clr         restart all counters at window (0,0), tap (0,0)
//   i_k_step      advance the kernel tap (kj inner, ki outer, wraps after 4 taps)
//   i_win_next    advance the output window (j inner, i outer)
//   o_img_addr    image address of the current tap: 8*(i+ki) + (j+kj)
//   o_ker_addr    kernel address of the current tap: 2*ki + kj
//   o_out_addr    output address of the current window: 8*i + j
//   o_last_win    current window is (6,6)
module conv_win_ctr
  import conv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_k_step,
  input  logic       i_win_next,
  output logic [5:0] o_img_addr,
  output logic [1:0] o_ker_addr,
  output logic [5:0] o_out_addr,
  output logic       o_last_win
);

  localparam logic [2:0] LastIdx = 3'(OUT_DIM - 1);

  logic [2:0] r_i;
  logic [2:0] r_j;
  logic       r_ki;
  logic       r_kj;
  logic [2:0] w_row;
  logic [2:0] w_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i  <= '0;
      r_j  <= '0;
      r_ki <= 1'b0;
      r_kj <= 1'b0;
    end else if (i_clr) begin
      r_i  <= '0;
      r_j  <= '0;
      r_ki <= 1'b0;
      r_kj <= 1'b0;
    end else begin
      if (i_k_step) begin
        r_kj <= ~r_kj;
        if (r_kj) begin
          r_ki <= ~r_ki;
        end
      end
      if (i_win_next) begin
        if (r_j == LastIdx) begin
          r_j <= '0;
          r_i <= r_i + 3'd1;
        end else begin
          r_j <= r_j + 3'd1;
        end
      end
    end
  end

  // i+ki and j+kj never exceed 7, so 3 bits suffice.
  assign w_row      = r_i + {2'b00, r_ki};
  assign w_col      = r_j + {2'b00, r_kj};
  assign o_img_addr = {w_row, w_col};
  assign o_ker_addr = {r_ki, r_kj};
  assign o_out_addr = {r_i, r_j};
  assign o_last_win = (r_i == LastIdx) && (r_j == LastIdx);

endmodule

// File: rtl/convolution_core.sv
// 2x2 valid convolution of an 8x8 image into a 7x7 result stored row-major in an 8x8 buffer.
// Kernel is loaded once per run (5 cycles), then each window takes 6 cycles:
// 4 image reads, 1 drain, 1 write.
// Build option: define CONV_RELU_EN to clamp negative results to 0 (timing unchanged).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   tstart                start pulse, accepted only in IDLE
//   v0_addr/rd_en/rd_data image read port (data valid the cycle after rd_en)
//   v1_addr/rd_en/rd_data kernel read port (data valid the cycle after rd_en)
//   v2_addr/wr_en/wr_data result write port
//   done                  one-cycle completion pulse
module convolution_core
  import conv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tstart,
  output logic [5:0]  v0_addr,
  output logic        v0_rd_en,
  input  logic [31:0] v0_rd_data,
  output logic [1:0]  v1_addr,
  output logic        v1_rd_en,
  input  logic [31:0] v1_rd_data,
  output logic [5:0]  v2_addr,
  output logic        v2_wr_en,
  output logic [31:0] v2_wr_data,
  output logic        done
);

  state_e            r_state;
  logic [2:0]        r_step;
  logic [DATA_W-1:0] r_kernel [K_DIM*K_DIM];
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_v0_rd_en;
  logic              r_v1_rd_en;
  logic              r_wr_en;
  logic              r_done;

  logic              w_clr;
  logic              w_k_step;
  logic              w_win_next;
  logic              w_last_win;
  logic [1:0]        w_kidx;
  logic [DATA_W-1:0] w_prod;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_result;
  logic [5:0]        w_img_addr;
  logic [1:0]        w_ker_addr;
  logic [5:0]        w_out_addr;

  conv_win_ctr u_win_ctr (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_k_step   (w_k_step),
    .i_win_next (w_win_next),
    .o_img_addr (w_img_addr),
    .o_ker_addr (w_ker_addr),
    .o_out_addr (w_out_addr),
    .o_last_win (w_last_win)
  );

  // Read data arriving at step s belongs to the tap issued at step s-1 (steps 1..4 -> taps 0..3).
  assign w_kidx = r_step[1:0] - 2'd1;
  // Low 32 bits of the signed product; wraps modulo 2^32.
  assign w_prod = $signed(v0_rd_data) * $signed(r_kernel[w_kidx]);
  assign w_sum  = r_acc + w_prod;

`ifdef CONV_RELU_EN
  assign w_result = relu(w_sum);
`else
  assign w_result = w_sum;
`endif

  assign w_clr      = (r_state == StIdle) && tstart;
  // Taps are issued on steps 0..3 of both KLOAD and WIN.
  assign w_k_step   = ((r_state == StKload) || (r_state == StWin)) && !r_step[2];
  assign w_win_next = (r_state == StWin) && (r_step == 3'd5) && !w_last_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_step     <= '0;
      r_acc      <= '0;
      r_wr_data  <= '0;
      r_v0_rd_en <= 1'b0;
      r_v1_rd_en <= 1'b0;
      r_wr_en    <= 1'b0;
      r_done     <= 1'b0;
      for (int n = 0; n < K_DIM * K_DIM; n++) begin
        r_kernel[n] <= '0;
      end
    end else begin
      case (r_state)
        StIdle: begin
          if (tstart) begin
            r_state    <= StKload;
            r_step     <= '0;
            r_v1_rd_en <= 1'b1;
          end
        end
        StKload: begin
          if (r_step != 3'd0) begin
            r_kernel[w_kidx] <= v1_rd_data;
          end
          r_v1_rd_en <= (r_step < 3'd3);
          if (r_step == 3'd4) begin
            r_state    <= StWin;
            r_step     <= '0;
            r_v0_rd_en <= 1'b1;
          end else begin
            r_step <= r_step + 3'd1;
          end
        end
        StWin: begin
          r_v0_rd_en <= (r_step < 3'd3);
          r_step     <= r_step + 3'd1;
          case (r_step)
            3'd1: r_acc <= w_prod;
            3'd2,
            3'd3: r_acc <= w_sum;
            3'd4: begin
              r_wr_data <= w_result;
              r_wr_en   <= 1'b1;
            end
            3'd5: begin
              r_wr_en <= 1'b0;
              r_step  <= '0;
              if (w_last_win) begin
                r_state    <= StDone;
                r_done     <= 1'b1;
                r_v0_rd_en <= 1'b0;
              end else begin
                r_v0_rd_en <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign v0_addr    = w_img_addr;
  assign v0_rd_en   = r_v0_rd_en;
  assign v1_addr    = w_ker_addr;
  assign v1_rd_en   = r_v1_rd_en;
  assign v2_addr    = w_out_addr;
  assign v2_wr_en   = r_wr_en;
  assign v2_wr_data = r_wr_data;
  assign done       = r_done;

endmodule

// File: tb/tb_convolution_core.sv
module tb_convolution_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        tstart;
  logic [5:0]  v0_addr;
  logic        v0_rd_en;
  logic [31:0] v0_rd_data;
  logic [1:0]  v1_addr;
  logic        v1_rd_en;
  logic [31:0] v1_rd_data;
  logic [5:0]  v2_addr;
  logic        v2_wr_en;
  logic [31:0] v2_wr_data;
  logic        done;

  always #5 clk = ~clk;

  convolution_core dut (
    .clk        (clk),
    .rst        (rst),
    .tstart     (tstart),
    .v0_addr    (v0_addr),
    .v0_rd_en   (v0_rd_en),
    .v0_rd_data (v0_rd_data),
    .v1_addr    (v1_addr),
    .v1_rd_en   (v1_rd_en),
    .v1_rd_data (v1_rd_data),
    .v2_addr    (v2_addr),
    .v2_wr_en   (v2_wr_en),
    .v2_wr_data (v2_wr_data),
    .done       (done)
  );

  // Memory models: one-cycle read latency, garbage when not enabled.
  logic [31:0] img [64];
  logic [31:0] ker [4];

  always @(posedge clk) begin
    v0_rd_data <= v0_rd_en ? img[v0_addr] : 32'hDEAD_BEEF;
    v1_rd_data <= v1_rd_en ? ker[v1_addr] : 32'hBAD0_C0DE;
  end

  // Monitor, sampled on the falling edge. Cycle index is relative to the accepting edge.
  int          neg_cnt = 0;
  int          t0 = 0;
  int          wr_cnt, first_wr, last_wr, krd_cnt, ird_cnt, both_cnt, wr_after_rst;
  bit          rst_seen;
  int          done_q[$];
  logic [31:0] out_mem [64];
  bit          written [64];

  always @(negedge clk) begin
    neg_cnt = neg_cnt + 1;
    if (rst) rst_seen = 1'b1;
    if (v0_rd_en) ird_cnt = ird_cnt + 1;
    if (v1_rd_en) krd_cnt = krd_cnt + 1;
    if (v0_rd_en && v1_rd_en) both_cnt = both_cnt + 1;
    if (v2_wr_en) begin
      if (wr_cnt == 0) first_wr = neg_cnt - t0;
      last_wr = neg_cnt - t0;
      wr_cnt = wr_cnt + 1;
      out_mem[v2_addr] = v2_wr_data;
      written[v2_addr] = 1'b1;
      if (rst_seen) wr_after_rst = wr_after_rst + 1;
    end
    if (done) done_q.push_back(neg_cnt - t0);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] rx(input logic [31:0] x);
`ifdef CONV_RELU_EN
    return x[31] ? 32'd0 : x;
`else
    return x;
`endif
  endfunction

  function automatic int done_at(input int idx);
    return (done_q.size() > idx) ? done_q[idx] : -1;
  endfunction

  task automatic clear_log();
    wr_cnt = 0; first_wr = -1; last_wr = -1; krd_cnt = 0; ird_cnt = 0;
    both_cnt = 0; wr_after_rst = 0; rst_seen = 1'b0;
    done_q.delete();
    for (int n = 0; n < 64; n++) begin
      out_mem[n] = 32'h5A5A_5A5A;
      written[n] = 1'b0;
    end
  endtask

  // Start a run; optionally pulse tstart / assert rst at given cycles, or hold tstart high.
  task automatic run_conv(input int pulse_at, input int rst_at, input int budget, input bit hold);
    @(posedge clk); #1;
    clear_log();
    tstart = 1'b1;
    @(posedge clk); #1;
    tstart = hold;
    t0 = neg_cnt + 1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      if (hold) begin
        if (done_q.size() >= 2) tstart = 1'b0;
      end else begin
        tstart = (c == pulse_at);
      end
      rst = (c == rst_at);
      if (done_q.size() >= (hold ? 2 : 1) && c > done_q[done_q.size()-1] + 2) break;
    end
    tstart = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic load_img_a();
    for (int n = 0; n < 64; n++) img[n] = 32'(n + 1);
  endtask

  task automatic check_all_ones_run(input string tag);
    int bad;
    check({tag, "_wr_cnt"}, wr_cnt, 49);
    check({tag, "_first_wr_cycle"}, first_wr, 10);
    check({tag, "_last_wr_cycle"}, last_wr, 298);
    check({tag, "_done_cnt"}, done_q.size(), 1);
    check({tag, "_done_cycle"}, done_at(0), 299);
    bad = 0;
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7; j++)
        if (out_mem[8*i+j] !== 32'(4*(8*i+j) + 22)) bad++;
    check({tag, "_bad_values"}, bad, 0);
  endtask

  typedef struct {
    logic [3:0][31:0] k;
    int               addr;
    logic [31:0]      exp;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] k0, input logic [31:0] k1,
                              input logic [31:0] k2, input logic [31:0] k3,
                              input int addr, input logic [31:0] exp);
    vec_t v;
    v.k[0] = k0; v.k[1] = k1; v.k[2] = k2; v.k[3] = k3;
    v.addr = addr;
    v.exp  = exp;
    return v;
  endfunction

  vec_t             vecs [13];
  logic [3:0][31:0] cur_k;
  bit               have_k;
  int               bad;

  initial begin
    // Window with base p=8i+j over img[n]=n+1 sees p+1, p+2, p+9, p+10.
    vecs[0]  = mk(1, 1, 1, 1, 0, 22);
    vecs[1]  = mk(1, 1, 1, 1, 1, 26);
    vecs[2]  = mk(1, 1, 1, 1, 8, 54);
    vecs[3]  = mk(1, 1, 1, 1, 54, 238);
    vecs[4]  = mk(1, 0, 0, 0, 27, 28);
    vecs[5]  = mk(0, 0, 0, 1, 6, 16);
    vecs[6]  = mk(1, 2, 3, 4, 0, 72);
    vecs[7]  = mk(1, 2, 3, 4, 13, 202);
    vecs[8]  = mk(32'hFFFF_FFFF, 0, 0, 0, 0, rx(32'hFFFF_FFFF));
    vecs[9]  = mk(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 20, rx(32'hFFFF_FFF7));
    vecs[10] = mk(32'h4000_0000, 0, 0, 0, 3, 32'h0000_0000);
    vecs[11] = mk(32'h4000_0000, 0, 0, 0, 1, rx(32'h8000_0000));
    vecs[12] = mk(32'h4000_0000, 0, 0, 0, 0, 32'h4000_0000);

    rst = 1'b1;
    tstart = 1'b0;
    load_img_a();
    for (int n = 0; n < 4; n++) ker[n] = '0;
    clear_log();

    repeat (3) @(posedge clk);
    #1;
    check("rst_v0_addr", 32'(v0_addr), 0);
    check("rst_v0_rd_en", 32'(v0_rd_en), 0);
    check("rst_v1_addr", 32'(v1_addr), 0);
    check("rst_v1_rd_en", 32'(v1_rd_en), 0);
    check("rst_v2_addr", 32'(v2_addr), 0);
    check("rst_v2_wr_en", 32'(v2_wr_en), 0);
    check("rst_v2_wr_data", v2_wr_data, 0);
    check("rst_done", 32'(done), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Table-driven vectors; a new run only when the kernel changes.
    have_k = 1'b0;
    for (int n = 0; n < 13; n++) begin
      if (!have_k || vecs[n].k != cur_k) begin
        cur_k  = vecs[n].k;
        have_k = 1'b1;
        for (int t = 0; t < 4; t++) ker[t] = cur_k[t];
        run_conv(-1, -1, 400, 1'b0);
        check($sformatf("vec%0d_run_done", n), done_q.size(), 1);
      end
      check($sformatf("vec%0d_out[%0d]", n, vecs[n].addr), out_mem[vecs[n].addr], vecs[n].exp);
    end

    // All-ones kernel: timing, access counts and untouched addresses.
    for (int t = 0; t < 4; t++) ker[t] = 32'd1;
    run_conv(-1, -1, 400, 1'b0);
    check_all_ones_run("ones");
    check("ones_kernel_reads", krd_cnt, 4);
    check("ones_image_reads", ird_cnt, 196);
    check("ones_both_enables", both_cnt, 0);
    bad = 0;
    for (int a = 0; a < 64; a++)
      if (((a % 8) == 7 || a >= 56) && written[a]) bad++;
    check("ones_edge_writes", bad, 0);

    // Identity kernel over a scrambled image: every result equals the image word.
    for (int n = 0; n < 64; n++) img[n] = 32'h1234_5679 * 32'(n + 3);
    ker[0] = 32'd1; ker[1] = 32'd0; ker[2] = 32'd0; ker[3] = 32'd0;
    run_conv(-1, -1, 400, 1'b0);
    bad = 0;
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7; j++)
        if (out_mem[8*i+j] !== rx(img[8*i+j])) bad++;
    check("ident_bad_values", bad, 0);
    check("ident_wr_cnt", wr_cnt, 49);
    load_img_a();

    // Reset mid-run aborts with no further writes and no restart.
    for (int t = 0; t < 4; t++) ker[t] = 32'd1;
    run_conv(-1, 100, 400, 1'b0);
    check("abort_wr_after_rst", wr_after_rst, 0);
    check("abort_done_cnt", done_q.size(), 0);
    run_conv(-1, -1, 400, 1'b0);
    check_all_ones_run("post_rst");

    // tstart pulse inside a run is ignored.
    run_conv(50, -1, 400, 1'b0);
    repeat (350) @(posedge clk);
    #1;
    check_all_ones_run("mid_pulse");

    // tstart held high: back-to-back runs, second done 301 cycles after the first.
    run_conv(-1, -1, 800, 1'b1);
    repeat (350) @(posedge clk);
    #1;
    check("b2b_done_cnt", done_q.size(), 2);
    check("b2b_done0_cycle", done_at(0), 299);
    check("b2b_done1_cycle", done_at(1), 600);
    check("b2b_wr_cnt", wr_cnt, 98);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/convolution_core.md
CONVOLUTION_CORE -- requirements
Module: convolution_core

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: tstart  in  1  start pulse, sampled on clk.
REQ-004 SHALL have ports: v0_addr  out  6  image read address, row-major 8x8.
REQ-005 SHALL have ports: v0_rd_en  out  1  image read enable.
REQ-006 SHALL have ports: v0_rd_data  in  32  image data, valid the cycle after v0_rd_en.
REQ-007 SHALL have ports: v1_addr  out  2  kernel read address, row-major 2x2.
REQ-008 SHALL have ports: v1_rd_en  out  1  kernel read enable.
REQ-009 SHALL have ports: v1_rd_data  in  32  kernel data, valid the cycle after v1_rd_en.
REQ-010 SHALL have ports: v2_addr  out  6  output write address, row-major 8x8.
REQ-011 SHALL have ports: v2_wr_en  out  1  output write strobe, one word per cycle.
REQ-012 SHALL have ports: v2_wr_data  out  32  output write data.
REQ-013 SHALL have ports: done  out  1  one-cycle completion pulse.

Function
REQ-014 SHALL compute out[i][j] = sum over ki,kj in {0,1} of img[i+ki][j+kj]*k[ki][kj], for i,j in 0..6 (49 results).
REQ-015 SHALL write each result to v2_addr = 8*i + j, i outer, j inner; addresses with i=7 or j=7 are never written.
REQ-016 SHALL use signed 32-bit multiply and accumulate, truncated modulo 2^32; no saturation.
REQ-017 SHALL implement states IDLE -> KLOAD -> WIN -> DONE -> IDLE; tstart is accepted only in IDLE.
REQ-018 KLOAD SHALL span 5 cycles: kernel reads at addresses 0..3 in cycles 0..3 (cycle 0 = first cycle after the accepting edge), drain in cycle 4, kernel latched in registers.
REQ-019 Each window SHALL span 6 cycles: four image reads (ki,kj order 00,01,10,11), one drain cycle, one write cycle.
REQ-020 The first v2_wr_en SHALL occur in cycle 10; the last in cycle 298; done SHALL pulse in cycle 299, then return to IDLE.
REQ-021 The kernel SHALL be read exactly once per run; the image SHALL be read exactly 196 times.
REQ-022 At most one of v0_rd_en / v1_rd_en SHALL be high per cycle; addresses are don't-care when the enable is low.
REQ-023 tstart asserted outside IDLE SHALL be ignored; tstart held high in IDLE SHALL start back-to-back runs.

Reset
REQ-024 rst SHALL asynchronously force IDLE, clear counters, accumulator and kernel registers, and drive all enables, done and all addresses and data to 0.
REQ-025 Reset mid-run SHALL abort the run with no further writes; the next run requires a new tstart.

Configuration
REQ-026 With macro CONV_RELU_EN defined, negative results (bit 31 set) SHALL be written as 0; without it, raw results SHALL be written unchanged. Timing is identical in both cases.

Structure
REQ-027 Package conv_pkg SHALL hold IMG_DIM=8, K_DIM=2, OUT_DIM=7, DATA_W=32 and the state enum.
REQ-028 One sub-module conv_win_ctr SHALL generate (i, j, ki, kj) counters and addresses; the MAC and FSM remain in convolution_core.

Verification
REQ-029 img[n]=n+1, kernel all 1 -> out[0]=22, out[1]=26, out[8]=54, out[54]=238 (formula 4*(8i+j)+22); exactly 49 writes.
REQ-030 Same stimulus -> first write in cycle 10, done in cycle 299, addresses 7, 15 and 56..63 never written.
REQ-031 Kernel {1,0,0,0} -> out[8i+j] = img[8i+j] for all 49 positions.
REQ-032 Kernel {-1,0,0,0}, img as in REQ-029 -> without CONV_RELU_EN out[0]=0xFFFFFFFF; with CONV_RELU_EN out[0]=0.
REQ-033 rst asserted in cycle 100, then tstart -> no writes after reset; full correct run with correct timing.
REQ-034 tstart pulsed in cycle 50 during a run -> ignored; single done pulse in cycle 299.
